// File: rtl/router_reg_param.sv
// Router datapath register stage.
// Latches the packet header and forwards payload bytes to the FIFO write side.
// Holds one byte while the FIFO is full.
// Accumulates packet parity and checks it against the trailing parity byte.
// Also checks the payload byte count against the header length field.
module router_reg_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned LEN_CHECK  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  rst_int_reg,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic                  len_err,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] PAR_INIT = (ODD_PARITY != 0) ? '1 : '0;

    logic [DATA_WIDTH-1:0] hdr_q,       hdr_d;
    logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
    logic [DATA_WIDTH-1:0] int_par_q,   int_par_d;
    logic [DATA_WIDTH-1:0] pkt_par_q,   pkt_par_d;
    logic [DATA_WIDTH-1:0] dout_q,      dout_d;
    logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
    logic                  parity_done_q, parity_done_d;
    logic                  pd_prev_q,     pd_prev_d;
    logic                  low_pkt_q,     low_pkt_d;
    logic                  err_q,         err_d;
    logic                  len_err_q,     len_err_d;

    logic [ADDR_WIDTH-1:0] addr_c;
    logic [CNT_WIDTH-1:0]  hdr_len_c;
    logic                  hdr_ok_c;
    logic                  lfd_c;
    logic                  ld_c;
    logic                  laf_c;
    logic                  pd_rise_c;

    // Header decode and FSM strobes.
    // detect_add masks the load strobes, so an illegal overlap with ld_state is ignored.
    always_comb begin
        addr_c    = data_in[ADDR_WIDTH-1:0];
        hdr_len_c = {1'b0, hdr_q[DATA_WIDTH-1:ADDR_WIDTH]};
        hdr_ok_c  = detect_add & pkt_valid & (32'(addr_c) < NUM_PORTS);
        lfd_c     = ~detect_add & lfd_state;
        ld_c      = ~detect_add & ld_state;
        laf_c     = ~detect_add & laf_state;
        pd_rise_c = parity_done_q & ~pd_prev_q;
    end

    // Next-state logic for every register in the stage.
    always_comb begin
        hdr_d         = hdr_q;
        full_byte_d   = full_byte_q;
        int_par_d     = int_par_q;
        pkt_par_d     = pkt_par_q;
        dout_d        = dout_q;
        cnt_d         = cnt_q;
        parity_done_d = parity_done_q;
        pd_prev_d     = pd_prev_q;
        low_pkt_d     = low_pkt_q;
        err_d         = err_q;
        len_err_d     = len_err_q;

        if (detect_add) begin
            // A header for an unknown port leaves the whole stage untouched.
            if (hdr_ok_c) begin
                hdr_d         = data_in;
                int_par_d     = PAR_INIT;
                cnt_d         = '0;
                parity_done_d = 1'b0;
                pd_prev_d     = 1'b0;
                err_d         = 1'b0;
                len_err_d     = 1'b0;
            end
        end else begin
            pd_prev_d = parity_done_q;

            if (lfd_c) begin
                int_par_d = int_par_q ^ hdr_q;
            end else if (ld_c && pkt_valid && !full_state) begin
                int_par_d = int_par_q ^ data_in;
                cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            end

            if (ld_c && !pkt_valid) begin
                pkt_par_d = data_in;
            end

            if ((ld_c && !fifo_full && !pkt_valid) ||
                (laf_c && low_pkt_q && !parity_done_q)) begin
                parity_done_d = 1'b1;
            end

            // Verdicts are taken the cycle after parity_done rises, when pkt_par is settled.
            if (pd_rise_c) begin
                err_d     = (int_par_q != pkt_par_q);
                len_err_d = (LEN_CHECK != 0) && (cnt_q != hdr_len_c);
            end
        end

        // Output byte path.
        // While the FIFO is full, the incoming byte is parked and dout holds.
        if (lfd_c) begin
            dout_d = hdr_q;
        end else if (ld_c && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_c && fifo_full) begin
            full_byte_d = data_in;
        end else if (laf_c) begin
            dout_d = full_byte_q;
        end

        // Low-packet-valid flag.
        // Setting wins over the FSM clear when both happen in the same cycle.
        if (rst_int_reg) begin
            low_pkt_d = 1'b0;
        end
        if (ld_c && !pkt_valid) begin
            low_pkt_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_q         <= '0;
            full_byte_q   <= '0;
            int_par_q     <= '0;
            pkt_par_q     <= '0;
            dout_q        <= '0;
            cnt_q         <= '0;
            parity_done_q <= 1'b0;
            pd_prev_q     <= 1'b0;
            low_pkt_q     <= 1'b0;
            err_q         <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            hdr_q         <= hdr_d;
            full_byte_q   <= full_byte_d;
            int_par_q     <= int_par_d;
            pkt_par_q     <= pkt_par_d;
            dout_q        <= dout_d;
            cnt_q         <= cnt_d;
            parity_done_q <= parity_done_d;
            pd_prev_q     <= pd_prev_d;
            low_pkt_q     <= low_pkt_d;
            err_q         <= err_d;
            len_err_q     <= len_err_d;
        end
    end

    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_q;
    assign err           = err_q;
    assign len_err       = len_err_q;
    assign dout          = dout_q;

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param.
// Drives whole packets the way the router FSM would.
// Checks results against a packet-level model: the byte stream, XOR parity, and length compare.
// A second instance is built with odd parity and the length check disabled.
module tb_router_reg_param;

    logic       clock = 1'b0;
    logic       reset, pkt_valid, fifo_full, rst_int_reg;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic [7:0] data_in;

    logic       parity_done, low_pkt_valid, err, len_err;
    logic [7:0] dout;
    logic       parity_done_o, low_pkt_valid_o, err_o, len_err_o;
    logic [7:0] dout_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Packet-level expectations carried between packets
    logic       exp_pd, exp_err, exp_err_o, exp_len, exp_lpv;
    logic [7:0] exp_dout;
    logic [7:0] pl[$];

    always #5 clock = ~clock;

    router_reg_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .ODD_PARITY(0), .LEN_CHECK(1)
    ) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .err(err), .len_err(len_err), .dout(dout)
    );

    router_reg_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .ODD_PARITY(1), .LEN_CHECK(0)
    ) dut_odd (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .parity_done(parity_done_o), .low_pkt_valid(low_pkt_valid_o),
        .err(err_o), .len_err(len_err_o), .dout(dout_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        rst_int_reg = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_pd"},   32'(parity_done), 32'(exp_pd));
        check_eq({tag, "_err"},  32'(err),         32'(exp_err));
        check_eq({tag, "_erro"}, 32'(err_o),       32'(exp_err_o));
        check_eq({tag, "_len"},  32'(len_err),     32'(exp_len));
        check_eq({tag, "_dout"}, 32'(dout),        32'(exp_dout));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dout"},  32'(dout),            32'h0);
        check_eq({tag, "_douto"}, 32'(dout_o),          32'h0);
        check_eq({tag, "_pd"},    32'(parity_done),     32'h0);
        check_eq({tag, "_lpv"},   32'(low_pkt_valid),   32'h0);
        check_eq({tag, "_err"},   32'(err),             32'h0);
        check_eq({tag, "_len"},   32'(len_err),         32'h0);
        check_eq({tag, "_erro"},  32'(err_o),           32'h0);
    endtask

    // Send header, payload in pl, and parity.
    // full_at selects the byte (pl.size() = parity byte) on which the FIFO reports full.
    task automatic send_pkt(input string tag, input logic [7:0] hdr, input logic [7:0] par,
                            input int full_at, input int full_wait);
        int         n;
        logic [7:0] calc;
        logic [7:0] b;
        n = pl.size();

        idle();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        step();
        detect_add = 1'b0;

        if (int'(hdr[1:0]) >= 3) begin
            idle();
            check_held({tag, "_inv"});
            step();
            check_held({tag, "_inv2"});
            return;
        end

        exp_pd = 1'b0; exp_err = 1'b0; exp_err_o = 1'b0; exp_len = 1'b0;
        check_held({tag, "_hdr"});

        lfd_state = 1'b1;
        step();
        lfd_state = 1'b0;
        exp_dout  = hdr;
        check_eq({tag, "_lfd_dout"}, 32'(dout), 32'(hdr));

        calc = hdr;
        for (int i = 0; i <= n; i++) begin
            b = (i < n) ? pl[i] : par;
            if (i < n) calc = calc ^ b;
            ld_state  = 1'b1;
            data_in   = b;
            pkt_valid = (i < n);
            fifo_full = (i == full_at);
            step();
            ld_state  = 1'b0;
            if (i == full_at) begin
                check_eq({tag, "_full_hold"}, 32'(dout), 32'(exp_dout));
                if (i == n) check_eq({tag, "_full_pd"}, 32'(parity_done), 32'h0);
                full_state = 1'b1;
                for (int w = 0; w < full_wait; w++) begin
                    step();
                    check_eq({tag, "_wait_hold"}, 32'(dout), 32'(exp_dout));
                end
                full_state = 1'b0;
                fifo_full  = 1'b0;
                laf_state  = 1'b1;
                data_in    = 8'($urandom);
                step();
                laf_state  = 1'b0;
            end
            exp_dout = b;
            check_eq({tag, "_dout"}, 32'(dout), 32'(b));
        end
        pkt_valid = 1'b0;

        check_eq({tag, "_pd"},      32'(parity_done),   32'h1);
        check_eq({tag, "_pdo"},     32'(parity_done_o), 32'h1);
        check_eq({tag, "_lpv"},     32'(low_pkt_valid), 32'h1);
        check_eq({tag, "_err_pre"}, 32'(err),           32'h0);

        exp_pd    = 1'b1;
        exp_err   = (calc != par);
        exp_err_o = (~calc != par);
        exp_len   = (n != int'(hdr[7:2]));

        step();
        check_eq({tag, "_err"},  32'(err),       32'(exp_err));
        check_eq({tag, "_erro"}, 32'(err_o),     32'(exp_err_o));
        check_eq({tag, "_len"},  32'(len_err),   32'(exp_len));
        check_eq({tag, "_leno"}, 32'(len_err_o), 32'h0);

        rst_int_reg = 1'b1;
        step();
        rst_int_reg = 1'b0;
        check_eq({tag, "_lpv_clr"}, 32'(low_pkt_valid), 32'h0);
        check_held({tag, "_post"});
    endtask

    task automatic load_seq(input int count);
        pl.delete();
        for (int i = 1; i <= count; i++) pl.push_back(8'(i));
    endtask

    initial begin
        idle();
        reset   = 1'b1;
        data_in = 8'h00;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        exp_pd = 1'b0; exp_err = 1'b0; exp_err_o = 1'b0; exp_len = 1'b0; exp_dout = 8'h00;

        load_seq(5);
        send_pkt("good", 8'h16, 8'h17, -1, 0);
        send_pkt("badpar", 8'h16, 8'hE8, -1, 0);
        send_pkt("invalid", 8'h17, 8'h00, -1, 0);
        load_seq(4);
        send_pkt("short", 8'h16, 8'h12, -1, 0);
        load_seq(5);
        send_pkt("ffull", 8'h16, 8'h17, 2, 2);
        send_pkt("ffull_par", 8'h16, 8'h17, 5, 1);
        pl.delete();
        send_pkt("len0", 8'h01, 8'h01, -1, 0);

        // Reset in the middle of a payload
        idle();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h16;
        step();
        detect_add = 1'b0; lfd_state = 1'b1;
        step();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h01;
        step();
        data_in = 8'h02;
        step();
        reset = 1'b1;
        step();
        idle();
        reset = 1'b0;
        check_all_zero("midrst");
        exp_pd = 1'b0; exp_err = 1'b0; exp_err_o = 1'b0; exp_len = 1'b0; exp_dout = 8'h00;
        load_seq(5);
        send_pkt("after_rst", 8'h16, 8'h17, -1, 0);

        // Randomized packets
        for (int k = 0; k < 60; k++) begin
            int         n, len, addr, full_at;
            logic [7:0] hdr, good, par;
            addr = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 8));
            len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : n;
            hdr  = {6'(len), 2'(addr)};
            pl.delete();
            good = hdr;
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom));
                good = good ^ pl[i];
            end
            par     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : good;
            full_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            send_pkt("rnd", hdr, par, full_at, int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
